mc_control: RTL
===============

# mc_control

Multicycle main controller for the MIPS CPU core. A Moore state machine sequences the shared datapath (PC, instruction register, register file, ALU, and the immediate extender) through fetch, decode, execute, memory and writeback steps. It generates every datapath enable and mux select, including the zero-extend select for the immediate extender. It sits between the instruction register opcode field and the single shared memory port, whose ready handshake it honours.

## Interface
Parameters:
- none. Opcodes come from `mips.h`: RTYPE 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, ADDI 6'b001000, ORI 6'b001101, J 6'b000010.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  opcode, instr[31:26] from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, asserted in FETCH, MEMRD and MEMWR
- mem_write  out  1  write strobe, asserted in MEMWR
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load
- pc_en  out  1  PC load: pc_write | (branch & zero)
- reg_write  out  1  register-file write
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback select: 1 = data register
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = or
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- zero_ext  out  1  extender zero-pads instead of sign-extending
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11.
- FETCH:
  - Drives iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00, mem_req=1.
  - Asserts ir_write and pc_write only in the cycle where mem_ready=1, then moves to DECODE.
  - Otherwise holds in FETCH.
- DECODE:
  - Drives src_a=0, src_b=11, alu_op=00, zero_ext=0; this computes the branch target.
  - Captures op into op_q.
  - Dispatches on op: LW/SW → MEMADR; RTYPE → RTYPEEX; BEQ → BEQEX; ADDI/ORI → IMMEX; J → JEX.
  - Any other opcode pulses illegal_op and returns to FETCH.
- MEMADR: src_a=1, src_b=10, alu_op=00. Goes to MEMRD if op_q=LW, else MEMWR.
- MEMRD: iord=1, mem_req=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_req=1, mem_write=1. Holds until mem_ready, then FETCH.
- RTYPEEX: src_a=1, src_b=00, alu_op=10, then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BEQEX: src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1, then FETCH.
- IMMEX: src_a=1, src_b=10, then IMMWB.
  - op_q=ADDI: alu_op=00, zero_ext=0.
  - op_q=ORI: alu_op=11, zero_ext=1.
- IMMWB:
  - reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
  - zero_ext keeps its IMMEX value.
- JEX: pc_src=10, pc_write=1, then FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on rising clk. reset_n low forces FETCH immediately, asynchronously, and clears op_q.
- While reset_n is low, all strobes are forced to 0: mem_req, mem_write, ir_write, pc_en, reg_write, illegal_op. Mux selects show FETCH values; state = 0.
- Reset mid-access (MEMRD, MEMWR, FETCH) abandons the access; no partial writeback occurs.
- Instruction latency with mem_ready=1 on every request:
  - BEQ and J: 3 cycles.
  - R-type, ADDI, ORI, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_write, mem_req and iord stay stable for every cycle of a stall.
- ir_write and pc_write fire exactly once per fetch.
- pc_en in BEQEX equals zero in that same cycle.

## Configuration
- `MC_CONTROL_ORI_EN`
  - Defined: ORI is decoded as described above.
  - Undefined: ORI is an illegal opcode; zero_ext is tied to 0 and alu_op never takes 11.

## Test plan
- Reset: reset_n=0 mid-MEMWR with mem_ready=0 → state=0 and mem_write=0 at once. After release, FETCH with mem_req=1.
- LW with mem_ready always 1 → states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1 and reg_dst=0.
- SW with mem_ready low for 3 cycles in MEMWR → state 5 held for 4 cycles with mem_write=1 and iord=1 throughout, then FETCH.
- BEQ: zero=1 → pc_en=1 and pc_src=01 in state 8; zero=0 → pc_en=0.
- ORI (macro defined) → IMMEX with zero_ext=1 and alu_op=11, then IMMWB with reg_write=1. Macro undefined: ORI → illegal_op pulse, state 1→0.
- Opcode 6'b111111 → illegal_op high for exactly one cycle in DECODE, no reg_write or mem_write, back to FETCH.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main controller (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback over a shared datapath and
// a single memory port with a ready handshake.
// Optional feature macro: MC_CONTROL_ORI_EN (decode ORI with zero-extended
// immediate). When undefined, ORI is illegal and zero_ext is tied to 0.
module mc_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       zero_ext,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTYPEEX = 4'd6, ALUWB = 4'd7,
    BEQEX   = 4'd8,  IMMEX  = 4'd9,  IMMWB  = 4'd10, JEX   = 4'd11
  } state_t;

  state_t     cur, nxt;
  logic [5:0] op_q;
  logic       illegal_raw;

  // next-state decode; illegal_raw flags an unrecognised opcode in DECODE
  always_comb begin
    nxt         = cur;
    illegal_raw = 1'b0;
    case (cur)
      FETCH:   if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = IMMEX;
`ifdef MC_CONTROL_ORI_EN
          OP_ORI:       nxt = IMMEX;
`endif
          OP_J:         nxt = JEX;
          default: begin
            nxt         = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR:  nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) nxt = MEMWB;
      MEMWR:   if (mem_ready) nxt = FETCH;
      RTYPEEX: nxt = ALUWB;
      IMMEX:   nxt = IMMWB;
      default: nxt = FETCH;
    endcase
  end

  // state register and opcode latch; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur  <= FETCH;
      op_q <= 6'd0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= op;
    end
  end

  logic mreq_raw, mwr_raw, irw_raw, pcw_raw, branch, regw_raw;

  // per-state datapath controls; strobes are gated by reset below
  always_comb begin
    mreq_raw   = 1'b0;
    mwr_raw    = 1'b0;
    irw_raw    = 1'b0;
    pcw_raw    = 1'b0;
    branch     = 1'b0;
    regw_raw   = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    zero_ext   = 1'b0;
    case (cur)
      FETCH: begin
        mreq_raw  = 1'b1;
        alu_src_b = 2'b01;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
      end
      DECODE:  alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mreq_raw = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        regw_raw   = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        mreq_raw = 1'b1;
        mwr_raw  = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst  = 1'b1;
        regw_raw = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
`ifdef MC_CONTROL_ORI_EN
        if (op_q == OP_ORI) begin
          alu_op   = 2'b11;
          zero_ext = 1'b1;
        end
`endif
      end
      IMMWB: begin
        regw_raw = 1'b1;
`ifdef MC_CONTROL_ORI_EN
        zero_ext = (op_q == OP_ORI);
`endif
      end
      JEX: begin
        pc_src  = 2'b10;
        pcw_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req    = reset_n & mreq_raw;
  assign mem_write  = reset_n & mwr_raw;
  assign ir_write   = reset_n & irw_raw;
  assign pc_en      = reset_n & (pcw_raw | (branch & zero));
  assign reg_write  = reset_n & regw_raw;
  assign illegal_op = reset_n & illegal_raw;
  assign state      = cur;

endmodule
